hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
//  Sequencing controller for the execute stage: shadows dest-register info of the EX, MEM and WB slots and drives
//  per-instruction forwarding selects for ALU operands 1/2 (registered, aligned to instruction entering EX).
//  Detects load-use hazards and inserts one bubble; freezes the pipeline while data memory is busy; honours branch flush.
// PARAMETERS
//  REG_AW   3   register-address width (8 GPRs)
//  CNT_W    16  width of perf counters (HAZ_PERF_CNT_EN only)
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous reset, active low
//  id_valid      in   1       decode slot holds a real instruction
//  id_src1       in   REG_AW  operand-1 source register
//  id_src1_used  in   1       operand 1 reads a register (not inport)
//  id_src2       in   REG_AW  operand-2 source register
//  id_src2_used  in   1       operand 2 reads a register (not imm/shift)
//  id_dst        in   REG_AW  destination register
//  id_reg_write  in   1       instruction writes id_dst
//  id_mem_read   in   1       instruction is a load
//  flush         in   1       taken branch: discard decode instruction
//  mem_busy      in   1       data memory not ready; freeze
//  forward1_sel  out  2       operand-1 select: 0 none, 1 EX/MEM, 2 MEM/WB
//  forward2_sel  out  2       operand-2 select, same encoding
//  stall         out  1       hold PC and IF/ID register this cycle
//  ex_bubble     out  1       load NOP into ID/EX register this cycle
//  stall_cycles  out  CNT_W   (HAZ_PERF_CNT_EN) cycles with stall=1, saturating
//  flush_count   out  CNT_W   (HAZ_PERF_CNT_EN) accepted flushes, saturating
// BEHAVIOUR
//  - Reset: all slots invalid, forward*_sel=0, state RUN, counters 0. stall/ex_bubble combinational, 0 in reset.
//  - Slot = {valid, dst, reg_write, mem_read}. Advance on clk when state!=MEM_WAIT and mem_busy=0:
//    wb<=mem; mem<=ex; ex<= (flush|lu_hit|!id_valid) ? bubble(valid=0) : decode fields.
//  - lu_hit = id_valid & ex.valid & ex.mem_read & ex.reg_write & ((src1_used&src1==ex.dst)|(src2_used&src2==ex.dst)).
//  - Forward select for operand n, registered on advance: if ex.valid&ex.reg_write&src_n_used&src_n==ex.dst -> 1;
//    else if mem.valid&mem.reg_write&match mem.dst -> 2; else 0. EX/MEM priority over MEM/WB. Loaded as 0 with bubble.
//  - Load-use: stall=1, ex_bubble=1 for exactly 1 cycle; next cycle load sits in MEM, dependant re-evaluates -> sel=2.
//  - FSM: RUN -> MEM_WAIT when mem_busy=1 (stall=1, ex_bubble=0, all slots and sels hold);
//    MEM_WAIT -> RUN on first cycle with mem_busy=0 (advance normally that edge). lu_hit masked while mem_busy.
//  - flush with lu_hit same cycle: flush wins, stall=0, ex_bubble=1. flush while mem_busy: ignored; source holds it.
//  - Latency: sel valid the cycle the instruction is in EX; stall/ex_bubble same-cycle from decode inputs.
//  - Reset mid-stall or mid-MEM_WAIT: immediate return to reset values; no partial slot state retained.
// CONFIGURATION
//  - HAZ_PERF_CNT_EN defined: stall_cycles increments each cycle stall=1; flush_count increments per accepted flush;
//    both saturate at all-ones, clear on reset. Undefined: both ports tied 0, no counter flops.
// STRUCTURE
//  - Shared package proc_pkg: FWD_NONE=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2; fwd_sel_t; hz_slot_t struct; state enum
//    (HZ_RUN, HZ_MEM_WAIT).
//  - One sub-module hz_fwd_match: combinational compare of one source vs ex/mem slots -> 2-bit select; instantiated x2.
// TESTING
//  - ADD R1 then ADD R2,R1,R3 back-to-back -> forward1_sel=1 for second, no stall.
//  - ADD R1; NOP; SUB R4,R5,R1 -> forward2_sel=2; ADD R1 twice then use R1 -> sel=1 (newest wins).
//  - LDD R2 then ADD R3,R2,R2 -> stall=1, ex_bubble=1 one cycle, then forward1_sel=forward2_sel=2.
//  - Load-use coinciding with flush=1 -> stall=0, ex_bubble=1, no stall_cycles increment.
//  - mem_busy high 3 cycles mid-sequence -> stall=1 x3, sels and slots frozen, resume identical to no-busy run.
//  - Assert rst_n=0 during MEM_WAIT -> sels 0, stall 0, counters 0 asynchronously; src*_used=0 -> sel always 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the execute-stage hazard/forwarding controller:
// forwarding-select encoding, pipeline slot record and controller states.
package proc_pkg;

    // Register-address width the slot record is built for (8 GPRs).
    localparam int HZ_REG_AW = 3;

    // ALU operand source select.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,   // register-file value
        FWD_EXMEM = 2'd1,   // result held in the EX/MEM register
        FWD_MEMWB = 2'd2    // result held in the MEM/WB register
    } fwd_sel_t;

    // Destination bookkeeping shadowed for one pipeline slot.
    typedef struct packed {
        logic                 valid;
        logic [HZ_REG_AW-1:0] dst;
        logic                 reg_write;
        logic                 mem_read;
    } hz_slot_t;

    // Controller states.
    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hz_fwd_match.sv
// Combinational forwarding match for one ALU source operand against the
// instructions currently in EX and MEM. The younger (EX) producer wins.
module hz_fwd_match
    import proc_pkg::*;
#(
    parameter int AW = HZ_REG_AW
) (
    input  logic [AW-1:0] src,
    input  logic          src_used,
    input  logic          ex_valid,
    input  logic          ex_reg_write,
    input  logic [AW-1:0] ex_dst,
    input  logic          mem_valid,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_dst,
    output fwd_sel_t      sel
);

    // Pick the newest in-flight producer of this source register.
    always_comb begin
        sel = FWD_NONE;
        if (src_used && ex_valid && ex_reg_write && (src == ex_dst)) begin
            sel = FWD_EXMEM;
        end else if (src_used && mem_valid && mem_reg_write && (src == mem_dst)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Execute-stage sequencing controller: tracks destination info of the
// instructions in EX and MEM, registers per-operand forwarding selects as an
// instruction enters EX, inserts one bubble on a load-use hazard, freezes
// while data memory is busy and honours branch flush.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating stall/flush counters;
// without it both counter ports are tied to zero.
module hazard_forward_ctrl
    import proc_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW,  // must match the slot record width
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic              id_src1_used,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              mem_busy,
    output logic [1:0]        forward1_sel,
    output logic [1:0]        forward2_sel,
    output logic              stall,
    output logic              ex_bubble,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    hz_state_t state_reg;
    hz_state_t state_next;

    // EX slot keeps the full record; the load flag matters only there.
    // Past EX only the forwarding fields are needed, and the instruction
    // leaving MEM is never a forwarding source, so no WB shadow is kept.
    hz_slot_t          ex_slot_reg;
    logic              mem_valid_reg;
    logic              mem_reg_write_reg;
    logic [REG_AW-1:0] mem_dst_reg;

    logic [1:0][REG_AW-1:0] src;
    logic [1:0]             src_used;
    logic [1:0]             ex_match;
    logic                   lu_hit;
    logic                   advance;
    logic                   insert_bubble;

    assign src      = {id_src2, id_src1};
    assign src_used = {id_src2_used, id_src1_used};

    // Slots only move when data memory is ready; in MEM_WAIT the first
    // not-busy cycle advances on that same edge.
    assign advance = !mem_busy;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            fwd_sel_t match_sel;
            fwd_sel_t sel_reg;

            hz_fwd_match #(
                .AW(REG_AW)
            ) u_match (
                .src          (src[gi]),
                .src_used     (src_used[gi]),
                .ex_valid     (ex_slot_reg.valid),
                .ex_reg_write (ex_slot_reg.reg_write),
                .ex_dst       (ex_slot_reg.dst),
                .mem_valid    (mem_valid_reg),
                .mem_reg_write(mem_reg_write_reg),
                .mem_dst      (mem_dst_reg),
                .sel          (match_sel)
            );

            // A source that matches the EX producer is exactly the load-use test.
            assign ex_match[gi] = (match_sel == FWD_EXMEM);

            // Select register travels with the instruction entering EX.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_reg <= FWD_NONE;
                end else if (advance) begin
                    sel_reg <= insert_bubble ? FWD_NONE : match_sel;
                end
            end
        end
    endgenerate

    assign forward1_sel = g_match[0].sel_reg;
    assign forward2_sel = g_match[1].sel_reg;

    assign lu_hit        = id_valid && ex_slot_reg.mem_read && (|ex_match);
    assign insert_bubble = flush || lu_hit || !id_valid;

    // Shift decode info into EX and EX info into MEM on every advancing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot_reg       <= '0;
            mem_valid_reg     <= 1'b0;
            mem_reg_write_reg <= 1'b0;
            mem_dst_reg       <= '0;
        end else if (advance) begin
            mem_valid_reg     <= ex_slot_reg.valid;
            mem_reg_write_reg <= ex_slot_reg.reg_write;
            mem_dst_reg       <= ex_slot_reg.dst;
            if (insert_bubble) begin
                ex_slot_reg <= '0;
            end else begin
                ex_slot_reg <= '{valid: 1'b1, dst: id_dst,
                                 reg_write: id_reg_write, mem_read: id_mem_read};
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HZ_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus stall/bubble; a busy memory masks the load-use check
    // and a flush overrides it (the dependant is being discarded anyway).
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        ex_bubble  = 1'b0;
        case (state_reg)
            HZ_RUN:      if (mem_busy)  state_next = HZ_MEM_WAIT;
            HZ_MEM_WAIT: if (!mem_busy) state_next = HZ_RUN;
        endcase
        if (mem_busy) begin
            stall = 1'b1;
        end else begin
            stall     = lu_hit && !flush;
            ex_bubble = lu_hit || flush;
        end
        if (!rst_n) begin
            stall     = 1'b0;
            ex_bubble = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] flush_count_reg;
    logic             flush_accepted;

    assign flush_accepted = flush && !mem_busy;

    // Saturating counters of stalled cycles and accepted flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end
            if (flush_accepted && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
